dac_multi_writer: RTL and testbench

Parametrised successor to the single-channel MCP47FEB I2C DAC writer. It writes up to NUM_CH DAC channel registers per update request, one I2C write transaction per selected channel. Each transaction is retried on a missed ACK, and per-channel errors are reported. The block drives the command/data stream interface of the existing i2c_master instance. Pin tristating and prescale stay with the instantiating wrapper.

---
 rtl/dac_multi_writer.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_dac_multi_writer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_multi_writer.sv
// dac_multi_writer: writes up to NUM_CH MCP47FEB DAC channel registers per
// update request, one I2C write transaction per selected channel, retrying a
// transaction after a missed ACK and flagging channels that never got through.
// Drives the command/data streams of an existing i2c_master instance.
module dac_multi_writer #(
  parameter int         NUM_CH    = 2,
  parameter int         DATA_W    = 12,
  parameter logic [6:0] DEV_ADDR  = 7'h60,
  parameter int         MAX_RETRY = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       update,
  input  logic [NUM_CH*DATA_W-1:0]   ch_values,
  input  logic [NUM_CH-1:0]          ch_mask,
  output logic                       busy,
  output logic                       done,
  output logic [NUM_CH-1:0]          err_mask,
  output logic [6:0]                 cmd_address,
  output logic                       cmd_start,
  output logic                       cmd_write_multiple,
  output logic                       cmd_stop,
  output logic                       cmd_valid,
  input  logic                       cmd_ready,
  output logic [7:0]                 data_in,
  output logic                       data_in_valid,
  output logic                       data_in_last,
  input  logic                       data_in_ready,
  input  logic                       missed_ack,
  input  logic                       master_busy
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SEL  = 3'd1,
    S_CMD  = 3'd2,
    S_REG  = 3'd3,
    S_HI   = 3'd4,
    S_LO   = 3'd5,
    S_WAIT = 3'd6,
    S_DONE = 3'd7
  } state_t;

  state_t                     state_q, state_d;
  logic [NUM_CH*DATA_W-1:0]   vals_q, vals_d;
  logic [NUM_CH-1:0]          rem_q, rem_d;
  logic [NUM_CH-1:0]          err_q, err_d;
  logic [4:0]                 ch_q, ch_d;
  logic [RW-1:0]              retry_q, retry_d;
  logic                       nack_q, nack_d;
  logic                       pend_q, pend_d;
  logic [NUM_CH*DATA_W-1:0]   pvals_q, pvals_d;
  logic [NUM_CH-1:0]          pmask_q, pmask_d;
  logic                       done_q, done_d;
  logic                       busy_q, busy_d;
  logic [6:0]                 cmd_address_q, cmd_address_d;
  logic                       cmd_op_q, cmd_op_d;
  logic                       cmd_valid_q, cmd_valid_d;
  logic [7:0]                 data_q, data_d;
  logic                       dvalid_q, dvalid_d;
  logic                       dlast_q, dlast_d;

  logic                       sel_found_s;
  logic [4:0]                 sel_idx_s;
  logic [NUM_CH-1:0]          ch_oh_s;
  logic [DATA_W-1:0]          cur_code_s;
  logic [15:0]                code16_s;
  logic                       nack_now_s;
  logic                       start_s;
  logic                       zero_done_s;
  logic [NUM_CH*DATA_W-1:0]   start_vals_s;
  logic [NUM_CH-1:0]          start_mask_s;

  // Lowest remaining channel, plus one-hot and zero-extended code of the active channel
  always_comb begin
    sel_found_s = 1'b0;
    sel_idx_s   = 5'd0;
    ch_oh_s     = {NUM_CH{1'b0}};
    cur_code_s  = {DATA_W{1'b0}};
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rem_q[i]) begin
        sel_found_s = 1'b1;
        sel_idx_s   = 5'(i);
      end else begin
        sel_found_s = sel_found_s;
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_q == 5'(i)) begin
        ch_oh_s[i] = 1'b1;
        cur_code_s = vals_q[i*DATA_W +: DATA_W];
      end else begin
        ch_oh_s[i] = 1'b0;
      end
    end
    code16_s = 16'(cur_code_s);
  end

  // Next-state, batch bookkeeping and registered-output values
  always_comb begin
    state_d      = state_q;
    vals_d       = vals_q;
    rem_d        = rem_q;
    err_d        = err_q;
    ch_d         = ch_q;
    retry_d      = retry_q;
    pend_d       = pend_q;
    pvals_d      = pvals_q;
    pmask_d      = pmask_q;
    start_s      = 1'b0;
    zero_done_s  = 1'b0;
    start_vals_s = ch_values;
    start_mask_s = ch_mask;
    nack_now_s   = nack_q | missed_ack;

    // A missed ACK anywhere inside a transaction marks it as failed.
    if (missed_ack && (state_q inside {S_CMD, S_REG, S_HI, S_LO, S_WAIT})) begin
      nack_d = 1'b1;
    end else begin
      nack_d = nack_q;
    end

    // Requests arriving mid-batch park in a one-deep buffer; the latest one wins.
    if (update && (state_q != S_IDLE)) begin
      pend_d  = 1'b1;
      pvals_d = ch_values;
      pmask_d = ch_mask;
    end else begin
      pend_d  = pend_q;
    end

    case (state_q)
      S_IDLE: begin
        if (update) begin
          start_s = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEL: begin
        if (sel_found_s) begin
          ch_d    = sel_idx_s;
          retry_d = {RW{1'b0}};
          state_d = S_CMD;
        end else begin
          state_d = S_DONE;
        end
      end
      S_CMD: begin
        if (cmd_valid_q && cmd_ready) begin
          state_d = S_REG;
        end else begin
          state_d = S_CMD;
        end
      end
      S_REG: begin
        if (dvalid_q && data_in_ready) begin
          state_d = S_HI;
        end else begin
          state_d = S_REG;
        end
      end
      S_HI: begin
        if (dvalid_q && data_in_ready) begin
          state_d = S_LO;
        end else begin
          state_d = S_HI;
        end
      end
      S_LO: begin
        if (dvalid_q && data_in_ready) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_LO;
        end
      end
      S_WAIT: begin
        // The master is idle and ready again once the transaction has fully finished.
        if (!master_busy && cmd_ready) begin
          if (!nack_now_s) begin
            rem_d   = rem_q & ~ch_oh_s;
            state_d = S_SEL;
          end else if (int'(retry_q) < MAX_RETRY) begin
            retry_d = retry_q + RW'(1);
            state_d = S_CMD;
          end else begin
            err_d   = err_q | ch_oh_s;
            rem_d   = rem_q & ~ch_oh_s;
            state_d = S_SEL;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DONE: begin
        // A request landing in this very cycle is newer than anything pending.
        if (update) begin
          start_s = 1'b1;
          pend_d  = 1'b0;
        end else if (pend_q) begin
          start_s      = 1'b1;
          start_vals_s = pvals_q;
          start_mask_s = pmask_q;
          pend_d       = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (start_s) begin
      vals_d = start_vals_s;
      rem_d  = start_mask_s;
      if (start_mask_s == {NUM_CH{1'b0}}) begin
        zero_done_s = 1'b1;
        state_d     = S_IDLE;
      end else begin
        err_d   = {NUM_CH{1'b0}};
        state_d = S_SEL;
      end
    end else begin
      vals_d = vals_d;
    end

    // Every (re)entry into CMD starts a fresh attempt with a clean NACK flag.
    if ((state_d == S_CMD) && (state_q != S_CMD)) begin
      nack_d = 1'b0;
    end else begin
      nack_d = nack_d;
    end

    // Outputs follow the state being entered so they are valid from its first cycle.
    busy_d        = (state_d != S_IDLE);
    done_d        = (state_d == S_DONE) || zero_done_s;
    cmd_valid_d   = (state_d == S_CMD);
    cmd_op_d      = (state_d == S_CMD);
    cmd_address_d = (state_d == S_CMD) ? DEV_ADDR : 7'd0;
    dvalid_d      = (state_d inside {S_REG, S_HI, S_LO});
    dlast_d       = (state_d == S_LO);
    case (state_d)
      S_REG:   data_d = {ch_q, 3'b000};
      S_HI:    data_d = code16_s[15:8];
      S_LO:    data_d = code16_s[7:0];
      default: data_d = 8'h00;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      vals_q        <= {(NUM_CH*DATA_W){1'b0}};
      rem_q         <= {NUM_CH{1'b0}};
      err_q         <= {NUM_CH{1'b0}};
      ch_q          <= 5'd0;
      retry_q       <= {RW{1'b0}};
      nack_q        <= 1'b0;
      pend_q        <= 1'b0;
      pvals_q       <= {(NUM_CH*DATA_W){1'b0}};
      pmask_q       <= {NUM_CH{1'b0}};
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      cmd_address_q <= 7'd0;
      cmd_op_q      <= 1'b0;
      cmd_valid_q   <= 1'b0;
      data_q        <= 8'h00;
      dvalid_q      <= 1'b0;
      dlast_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      vals_q        <= vals_d;
      rem_q         <= rem_d;
      err_q         <= err_d;
      ch_q          <= ch_d;
      retry_q       <= retry_d;
      nack_q        <= nack_d;
      pend_q        <= pend_d;
      pvals_q       <= pvals_d;
      pmask_q       <= pmask_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
      cmd_address_q <= cmd_address_d;
      cmd_op_q      <= cmd_op_d;
      cmd_valid_q   <= cmd_valid_d;
      data_q        <= data_d;
      dvalid_q      <= dvalid_d;
      dlast_q       <= dlast_d;
    end
  end

  assign busy               = busy_q;
  assign done               = done_q;
  assign err_mask           = err_q;
  assign cmd_address        = cmd_address_q;
  assign cmd_start          = cmd_op_q;
  assign cmd_write_multiple = cmd_op_q;
  assign cmd_stop           = cmd_op_q;
  assign cmd_valid          = cmd_valid_q;
  assign data_in            = data_q;
  assign data_in_valid      = dvalid_q;
  assign data_in_last       = dlast_q;

endmodule

// File: tb/tb_dac_multi_writer.sv
// Bench for dac_multi_writer: an i2c_master responder plus a transaction-level
// model of which register writes each batch must produce and which channels fail.
module tb_dac_multi_writer;

  localparam int MAXR = 3;

  logic        clk = 1'b0;
  logic        rst, update;
  logic [23:0] ch_values;
  logic [1:0]  ch_mask;
  logic        busy, done;
  logic [1:0]  err_mask;
  logic [6:0]  cmd_address;
  logic        cmd_start, cmd_write_multiple, cmd_stop, cmd_valid, cmd_ready;
  logic [7:0]  data_in;
  logic        data_in_valid, data_in_last, data_in_ready;
  logic        missed_ack, master_busy;

  int checks = 0;
  int errors = 0;

  logic [23:0] exp_tx_q[$];
  bit          nack_plan_q[$];

  bit          m_busy, tail_nack, fast, stall_lo;
  int          tail, byte_cnt, cyc, cmd_cyc, stall_hi, done_cnt;
  logic [23:0] cur_tx;

  dac_multi_writer #(.NUM_CH(2), .DATA_W(12), .DEV_ADDR(7'h60), .MAX_RETRY(MAXR)) dut (
    .clk(clk), .rst(rst), .update(update), .ch_values(ch_values), .ch_mask(ch_mask),
    .busy(busy), .done(done), .err_mask(err_mask),
    .cmd_address(cmd_address), .cmd_start(cmd_start), .cmd_write_multiple(cmd_write_multiple),
    .cmd_stop(cmd_stop), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .data_in(data_in), .data_in_valid(data_in_valid), .data_in_last(data_in_last),
    .data_in_ready(data_in_ready), .missed_ack(missed_ack), .master_busy(master_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Model: n = number of consecutive NACKed attempts a channel will see.
  task automatic plan_batch(input logic [23:0] vals, input logic [1:0] mask,
                            input int n0, input int n1, output logic [1:0] exp_err);
    int n, attempts;
    logic [11:0] code;
    logic [7:0]  regb;
    exp_err = 2'b00;
    for (int c = 0; c < 2; c++) begin
      if (mask[c]) begin
        n        = (c == 0) ? n0 : n1;
        code     = vals[c*12 +: 12];
        regb     = 8'(c * 8);
        attempts = (n > MAXR) ? MAXR + 1 : n + 1;
        for (int k = 0; k < attempts; k++) begin
          exp_tx_q.push_back({regb, 4'h0, code});
          nack_plan_q.push_back(k < n);
        end
        if (n > MAXR) exp_err[c] = 1'b1;
      end
    end
  endtask

  task automatic do_update(input logic [23:0] vals, input logic [1:0] mask);
    ch_values = vals;
    ch_mask   = mask;
    update    = 1'b1;
    @(posedge clk); #2;
    update    = 1'b0;
    ch_values = 24'($urandom);
    ch_mask   = 2'($urandom);
  endtask

  task automatic wait_done(input string tag, input logic [1:0] exp_err);
    int n = 0;
    while (done !== 1'b1 && n < 3000) begin
      @(posedge clk); #2;
      n++;
    end
    chk({tag, "_done_seen"}, done, 1'b1);
    chk({tag, "_err_mask"}, err_mask, exp_err);
  endtask

  task automatic run_batch(input string tag, input logic [23:0] vals, input logic [1:0] mask,
                           input int n0, input int n1);
    logic [1:0] e;
    int d0;
    plan_batch(vals, mask, n0, n1, e);
    d0 = done_cnt;
    do_update(vals, mask);
    chk({tag, "_busy"}, busy, (mask != 2'b00));
    wait_done(tag, e);
    repeat (3) begin @(posedge clk); #2; end
    chk({tag, "_done_once"}, done_cnt - d0, 1);
    chk({tag, "_drained"}, exp_tx_q.size() + nack_plan_q.size(), 0);
    chk({tag, "_idle"}, busy, 1'b0);
  endtask

  // i2c_master responder and stream monitor, acting on the falling edge
  initial begin
    cmd_ready = 1'b0; data_in_ready = 1'b0; missed_ack = 1'b0; master_busy = 1'b0;
    m_busy = 0; tail = 0; byte_cnt = 0; cyc = 0; cmd_cyc = 0; done_cnt = 0; cur_tx = 24'h0;
    tail_nack = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        m_busy = 0; tail = 0; byte_cnt = 0; missed_ack = 1'b0;
        master_busy = 1'b0; cmd_ready = 1'b0; data_in_ready = 1'b0;
      end else begin
        missed_ack = 1'b0;
        if (tail > 0) begin
          tail--;
          if (tail == 1 && tail_nack) missed_ack = 1'b1;
          if (tail == 0) m_busy = 0;
        end
        master_busy = m_busy;
        cmd_ready   = !m_busy;
        if (byte_cnt == 1 && stall_hi > 0) begin
          data_in_ready = 1'b0;
          stall_hi--;
          chk("hi_hold_valid", data_in_valid, 1'b1);
          if (exp_tx_q.size() > 0) chk("hi_hold_data", data_in, exp_tx_q[0][15:8]);
          else chk("hi_hold_noexp", exp_tx_q.size(), 1);
        end else if (stall_lo && data_in_valid && data_in_last) begin
          data_in_ready = 1'b0;
        end else if (fast) begin
          data_in_ready = 1'b1;
        end else begin
          data_in_ready = ($urandom_range(0, 3) != 0);
        end

        if (cmd_valid && cmd_ready) begin
          chk("cmd_addr", cmd_address, 7'h60);
          chk("cmd_flags", {cmd_start, cmd_write_multiple, cmd_stop}, 3'b111);
          m_busy = 1; master_busy = 1'b1;
          cmd_cyc = cyc; byte_cnt = 0;
          if (nack_plan_q.size() > 0) tail_nack = nack_plan_q.pop_front();
          else begin chk("cmd_unexpected", nack_plan_q.size(), 1); tail_nack = 0; end
        end
        if (data_in_valid && data_in_ready) begin
          cur_tx = {cur_tx[15:0], data_in};
          chk("last_flag", data_in_last, (byte_cnt == 2));
          if (fast) chk("byte_latency", cyc - cmd_cyc, byte_cnt + 1);
          byte_cnt++;
          if (data_in_last) begin
            if (exp_tx_q.size() > 0) chk("tx_bytes", cur_tx, exp_tx_q.pop_front());
            else chk("tx_unexpected", exp_tx_q.size(), 1);
            tail = $urandom_range(2, 5);
          end
        end
        if (done) done_cnt++;
      end
    end
  end

  // Directed and randomized scenario sequence
  initial begin
    logic [1:0]  e;
    logic [23:0] v;
    int d0, n;
    rst = 1'b1; update = 1'b0; ch_values = 24'h0; ch_mask = 2'b00;
    fast = 1; stall_lo = 0; stall_hi = 0;
    repeat (3) begin @(posedge clk); #2; end
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err_mask, 2'b00);
    chk("rst_valids", {cmd_valid, data_in_valid, data_in_last}, 3'b000);
    chk("rst_cmd", {cmd_address, cmd_start, cmd_write_multiple, cmd_stop}, 10'h0);
    rst = 1'b0;
    @(posedge clk); #2;

    run_batch("single_ch0", {12'h000, 12'hABC}, 2'b01, 0, 0);
    run_batch("both_ch", {12'hFFF, 12'h123}, 2'b11, 0, 0);
    run_batch("zero_mask", 24'h5A5A5A, 2'b00, 0, 0);

    fast = 0;
    run_batch("ch1_retry_once", {12'($urandom), 12'($urandom)}, 2'b11, 0, 1);
    run_batch("ch0_exhaust", {12'($urandom), 12'($urandom)}, 2'b11, 4, 0);
    run_batch("ch1_last_retry_ok", {12'($urandom), 12'($urandom)}, 2'b10, 0, 3);

    // Two requests while busy: only the latest pending one runs afterwards.
    plan_batch({12'h0F0, 12'h3C3}, 2'b11, 0, 0, e);
    d0 = done_cnt;
    do_update({12'h0F0, 12'h3C3}, 2'b11);
    repeat (2) begin @(posedge clk); #2; end
    do_update({12'h777, 12'h111}, 2'b11);
    repeat (2) begin @(posedge clk); #2; end
    v = {12'($urandom), 12'h555};
    do_update(v, 2'b01);
    wait_done("pend_first", e);
    plan_batch(v, 2'b01, 0, 0, e);
    @(posedge clk); #2;
    wait_done("pend_second", e);
    repeat (3) begin @(posedge clk); #2; end
    chk("pend_done_count", done_cnt - d0, 2);
    chk("pend_drained", exp_tx_q.size() + nack_plan_q.size(), 0);

    // Ready withheld for five cycles while the high byte is on offer.
    stall_hi = 5;
    run_batch("hi_stall", {12'($urandom), 12'hA5C}, 2'b01, 0, 0);
    chk("hi_stall_used", stall_hi, 0);

    for (int i = 0; i < 6; i++) begin
      run_batch("rand", 24'($urandom), 2'($urandom), $urandom_range(0, 4), $urandom_range(0, 4));
    end

    // Reset while the low byte of channel 1 is waiting, after channel 0 has failed.
    plan_batch(24'h2C53A7, 2'b11, 4, 0, e);
    do_update(24'h2C53A7, 2'b11);
    n = 0;
    while (err_mask !== 2'b01 && n < 3000) begin @(posedge clk); #2; n++; end
    chk("rst_pre_err", err_mask, 2'b01);
    stall_lo = 1;
    n = 0;
    while (!(data_in_valid === 1'b1 && data_in_last === 1'b1) && n < 300) begin
      @(posedge clk); #2; n++;
    end
    chk("rst_in_lo", {data_in_valid, data_in_last}, 2'b11);
    rst = 1'b1;
    @(posedge clk); #2;
    chk("rst_lo_valids", {cmd_valid, data_in_valid, data_in_last}, 3'b000);
    chk("rst_lo_busy", busy, 1'b0);
    chk("rst_lo_err", err_mask, 2'b00);
    chk("rst_lo_done", done, 1'b0);
    rst = 1'b0;
    stall_lo = 0;
    exp_tx_q.delete();
    nack_plan_q.delete();
    repeat (2) begin @(posedge clk); #2; end
    run_batch("after_rst", {12'h0C0, 12'hDEF}, 2'b11, 0, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
